// File: rtl/dp_pkg.sv
// Shared types for the sequenced datapath.
// Opcodes, FSM states, shift codes and the B-operand shifter.
package dp_pkg;

  localparam int MAXW = 64;

  typedef enum logic [2:0] {
    OP_MOV_IMM = 3'd0,
    OP_MOV_SH  = 3'd1,
    OP_ADD     = 3'd2,
    OP_CMP     = 3'd3,
    OP_AND     = 3'd4,
    OP_MVN     = 3'd5,
    OP_LDW     = 3'd6,
    OP_RSVD    = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_A,
    S_LD_B,
    S_EXEC,
    S_WB
  } state_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL1 = 2'b01,
    SH_LSR1 = 2'b10,
    SH_ASR1 = 2'b11
  } shift_e;

  // Shift is done on a wide carrier; w is the
  // real word width, the caller slices [w-1:0].
  function automatic logic [MAXW-1:0] sh_f(
    input logic [MAXW-1:0] v,
    input shift_e          s,
    input int unsigned     w
  );
    logic [MAXW-1:0] msk;
    logic [MAXW-1:0] vm;
    logic [MAXW-1:0] top;
    logic [MAXW-1:0] r;
    msk = {MAXW{1'b1}} >> (MAXW - w);
    vm  = v & msk;
    top = {{(MAXW-1){1'b0}}, vm[w-1]} << (w - 1);
    unique case (s)
      SH_LSL1: r = (vm << 1) & msk;
      SH_LSR1: r = vm >> 1;
      SH_ASR1: r = (vm >> 1) | top;
      default: r = vm;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dp_regfile.sv
// General register file: one async read, one sync write port.
// Ports: clk, rst_n, raddr/rdata, we/waddr/wdata.
module dp_regfile
  import dp_pkg::*;
#(
  parameter int W    = 16,
  parameter int NREG = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [$clog2(NREG)-1:0] raddr,
  output logic [W-1:0]            rdata,
  input  logic                    we,
  input  logic [$clog2(NREG)-1:0] waddr,
  input  logic [W-1:0]            wdata
);

  localparam int AW = $clog2(NREG);

  logic [W-1:0] regs [NREG];
  logic         r_ok;
  logic         w_ok;

  // Indices past NREG only exist when NREG
  // is not a power of two.
  generate
    if ((1 << AW) == NREG) begin : g_pow2
      assign r_ok = 1'b1;
      assign w_ok = 1'b1;
    end else begin : g_npow2
      assign r_ok = int'(raddr) < NREG;
      assign w_ok = int'(waddr) < NREG;
    end
  endgenerate

  assign rdata = r_ok ? regs[raddr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we && w_ok) begin
      regs[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/seq_datapath.sv
// Datapath with internal micro-sequencer: one request runs a full op.
// Ports: req_valid/req_ready, op/rd/rn/rm/shift/imm, mdata, done/result/status.
module seq_datapath
  import dp_pkg::*;
#(
  parameter int W    = 16,
  parameter int NREG = 8,
  parameter int IMMW = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [2:0]              op,
  input  logic [$clog2(NREG)-1:0] rd,
  input  logic [$clog2(NREG)-1:0] rn,
  input  logic [$clog2(NREG)-1:0] rm,
  input  logic [1:0]              shift,
  input  logic [IMMW-1:0]         imm,
  input  logic [W-1:0]            mdata,
  output logic                    done,
  output logic [W-1:0]            result,
  output logic [2:0]              status
);

  localparam int AW = $clog2(NREG);

  state_e         state;
  op_e            op_q;
  shift_e         sh_q;
  logic [AW-1:0]  rd_q;
  logic [AW-1:0]  rn_q;
  logic [AW-1:0]  rm_q;
  logic [IMMW-1:0] imm_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   c_q;
  logic [2:0]     st_q;

  logic [AW-1:0]  rf_raddr;
  logic [W-1:0]   rf_rdata;
  logic           rf_we;
  logic [W-1:0]   wb_val;
  logic [MAXW-1:0] sh_wide;
  logic [W-1:0]   bs;
  logic [W-1:0]   alu;
  logic           flag_v;
  op_e            op_in;
  logic           need_a;
  logic           need_b;

  assign op_in  = op_e'(op);
  assign need_a = op_in inside {OP_ADD, OP_CMP, OP_AND};
  assign need_b = op_in inside {OP_MOV_SH, OP_MVN};

  assign sh_wide = sh_f(MAXW'(b_q), sh_q, W);
  assign bs      = sh_wide[W-1:0];

  always_comb begin
    alu = '0;
    unique case (op_q)
      OP_ADD:    alu = a_q + bs;
      OP_CMP:    alu = a_q - bs;
      OP_AND:    alu = a_q & bs;
      OP_MVN:    alu = ~bs;
      OP_MOV_SH: alu = a_q + bs;
      default:   alu = '0;
    endcase
  end

  assign flag_v = (a_q[W-1] ^ bs[W-1])
                & (alu[W-1] ^ a_q[W-1]);

  always_comb begin
    wb_val = c_q;
    unique case (op_q)
      OP_MOV_IMM: wb_val = W'($signed(imm_q));
      OP_LDW:     wb_val = mdata;
      default:    wb_val = c_q;
    endcase
  end

  assign rf_raddr = (state == S_LD_A) ? rn_q : rm_q;
  assign rf_we    = (state == S_WB) && (op_q != OP_RSVD);

  assign req_ready = (state == S_IDLE);
  assign done = (state == S_WB)
             || (state == S_EXEC && op_q == OP_CMP);
  assign result = c_q;
  assign status = st_q;

  dp_regfile #(
    .W    (W),
    .NREG (NREG)
  ) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .raddr (rf_raddr),
    .rdata (rf_rdata),
    .we    (rf_we),
    .waddr (rd_q),
    .wdata (wb_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      op_q  <= OP_MOV_IMM;
      sh_q  <= SH_NONE;
      rd_q  <= '0;
      rn_q  <= '0;
      rm_q  <= '0;
      imm_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      st_q  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q  <= op_in;
            sh_q  <= shift_e'(shift);
            rd_q  <= rd;
            rn_q  <= rn;
            rm_q  <= rm;
            imm_q <= imm;
            // B-only ops see a zero A operand
            if (need_b) a_q <= '0;
            unique case (1'b1)
              need_a:  state <= S_LD_A;
              need_b:  state <= S_LD_B;
              default: state <= S_WB;
            endcase
          end
        end
        S_LD_A: begin
          a_q   <= rf_rdata;
          state <= S_LD_B;
        end
        S_LD_B: begin
          b_q   <= rf_rdata;
          state <= S_EXEC;
        end
        S_EXEC: begin
          c_q <= alu;
          if (op_q == OP_CMP) begin
            st_q  <= {alu[W-1], flag_v, alu == '0};
            state <= S_IDLE;
          end else begin
            state <= S_WB;
          end
        end
        S_WB: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
